// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS memory-side logic.
// Imported by the memory unit and anything decoding its instruction fields.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam int MAX_WAIT_CYCLES  = 15;

    function automatic logic is_misaligned(input logic [31:0] byte_addr);
        return byte_addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/mips_ram.sv
// Unified instruction/data word array: asynchronous read, synchronous write.
// Writes are dropped while write_suppress is high (misaligned store).
module mips_ram #(
    parameter int    ADDR_WIDTH = 8,
    parameter string INIT_FILE  = "memfile.dat"
) (
    input  logic                  clock,
    input  logic                  write_en,
    input  logic                  write_suppress,
    input  logic [ADDR_WIDTH-1:0] index,
    input  logic [31:0]           write_data,
    output logic [31:0]           read_data
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clock) begin
        if (write_en && !write_suppress) begin
            mem[index] <= write_data;
        end
    end

    assign read_data = mem[index];

endmodule

// File: rtl/mips_mem_unit.sv
// Memory responder for the multicycle MIPS core: address mux, IR, MDR and an
// optional wait-state engine that stretches each access by WAIT_CYCLES cycles.
module mips_mem_unit
    import mips_pkg::*;
#(
    parameter int    ADDR_WIDTH  = 8,
    parameter int    WAIT_CYCLES = 0,
    parameter string INIT_FILE   = "memfile.dat"
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        IorD,
    input  logic        IRWrite,
    input  logic        MemWrite,
    input  logic [31:0] pc,
    input  logic [31:0] alu_out,
    input  logic [31:0] write_data,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        misaligned
);

    logic [31:0]           addr;
    logic [ADDR_WIDTH-1:0] index;
    logic [31:0]           read_data;
    logic                  req;
    logic                  commit;
    logic                  ready_int;
    logic [31:0]           ir_reg;
    logic [31:0]           mdr_reg;
    logic                  unused_addr_bits;

    assign addr       = IorD ? alu_out : pc;
    assign index      = addr[ADDR_WIDTH+1:2];
    assign misaligned = is_misaligned(addr);
    assign req        = IRWrite | MemWrite | IorD;

    // Upper address bits fall off the top: accesses wrap modulo the depth.
    assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

    generate
        if (WAIT_CYCLES == 0) begin : g_single
            logic unused_req;

            assign unused_req = req;
            assign commit     = 1'b1;
            assign ready_int  = 1'b1;
        end else begin : g_wait
            mem_state_t state_reg, state_next;
            logic [3:0] count_reg, count_next;
            logic       ready_comb;
            logic       commit_comb;

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    count_reg <= count_next;
                end
            end

            // IDLE counts as the first stall cycle, so WAIT covers N-1 more.
            always_comb begin
                state_next  = state_reg;
                count_next  = count_reg;
                ready_comb  = 1'b0;
                commit_comb = 1'b0;
                case (state_reg)
                    IDLE: begin
                        ready_comb = !req;
                        if (req) begin
                            count_next = 4'(WAIT_CYCLES);
                            state_next = (WAIT_CYCLES == 1) ? DONE : WAIT;
                        end
                    end
                    WAIT: begin
                        count_next = count_reg - 4'd1;
                        if (count_reg == 4'd2) begin
                            state_next = DONE;
                        end
                    end
                    DONE: begin
                        ready_comb  = 1'b1;
                        commit_comb = 1'b1;
                        count_next  = '0;
                        state_next  = IDLE;
                    end
                    default: begin
                        state_next = IDLE;
                        count_next = '0;
                    end
                endcase
            end

            assign ready_int = ready_comb;
            assign commit    = commit_comb;
        end
    endgenerate

    // Gating with reset keeps an in-flight store from landing while reset is held.
    mips_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clock          (clock),
        .write_en       (MemWrite & commit & reset),
        .write_suppress (misaligned),
        .index          (index),
        .write_data     (write_data),
        .read_data      (read_data)
    );

    // IR and MDR sample the pre-write word, giving read-before-write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir_reg  <= '0;
            mdr_reg <= '0;
        end else if (commit) begin
            mdr_reg <= read_data;
            if (IRWrite) begin
                ir_reg <= read_data;
            end
        end
    end

    assign mem_ready = ready_int;
    assign mem_data  = mdr_reg;
    assign instr     = ir_reg;
    assign opcode    = ir_reg[31:26];
    assign rs        = ir_reg[25:21];
    assign rt        = ir_reg[20:16];
    assign rd        = ir_reg[15:11];
    assign imm       = ir_reg[15:0];
    assign funct     = ir_reg[5:0];

endmodule

// File: tb/tb_mips_mem_unit.sv
// Bench for mips_mem_unit: a single-cycle instance and a 3-wait-state instance
// checked against an array-based memory model, a vector table and hand sequences.
module tb_mips_mem_unit;
    import mips_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // single-cycle instance
    logic        a_iord, a_irw, a_mw;
    logic [31:0] a_pc, a_alu, a_wd;
    logic [31:0] a_instr, a_mem_data;
    logic [5:0]  a_opcode, a_funct;
    logic [4:0]  a_rs, a_rt, a_rd;
    logic [15:0] a_imm;
    logic        a_ready, a_mis;

    // wait-state instance
    logic        b_iord, b_irw, b_mw;
    logic [31:0] b_pc, b_alu, b_wd;
    logic [31:0] b_instr, b_mem_data;
    logic [5:0]  b_opcode, b_funct;
    logic [4:0]  b_rs, b_rt, b_rd;
    logic [15:0] b_imm;
    logic        b_ready, b_mis;

    mips_mem_unit #(.ADDR_WIDTH(8), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
        .clock(clock), .reset(reset), .IorD(a_iord), .IRWrite(a_irw), .MemWrite(a_mw),
        .pc(a_pc), .alu_out(a_alu), .write_data(a_wd), .instr(a_instr),
        .opcode(a_opcode), .funct(a_funct), .rs(a_rs), .rt(a_rt), .rd(a_rd),
        .imm(a_imm), .mem_data(a_mem_data), .mem_ready(a_ready), .misaligned(a_mis)
    );

    mips_mem_unit #(.ADDR_WIDTH(8), .WAIT_CYCLES(3), .INIT_FILE("")) dut3 (
        .clock(clock), .reset(reset), .IorD(b_iord), .IRWrite(b_irw), .MemWrite(b_mw),
        .pc(b_pc), .alu_out(b_alu), .write_data(b_wd), .instr(b_instr),
        .opcode(b_opcode), .funct(b_funct), .rs(b_rs), .rt(b_rt), .rd(b_rd),
        .imm(b_imm), .mem_data(b_mem_data), .mem_ready(b_ready), .misaligned(b_mis)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        iord, irw, mw;
        logic [31:0] pc, alu, wd;
        logic        exp_mis;
        logic [31:0] exp_instr;
        logic        chk_mdr;
        logic [31:0] exp_mdr;
    } vec_t;

    vec_t tbl[12];

    logic [31:0] a_model [256];
    logic [31:0] b_model [16];
    logic [31:0] a_ir, b_ir;
    logic [31:0] sel, other, wd, old;
    logic        iord, irw, mw, mis, mis_seen;
    int          idx, low;

    task automatic a_drive(input logic iord_i, irw_i, mw_i, input logic [31:0] p, alu, wdat);
        a_iord = iord_i; a_irw = irw_i; a_mw = mw_i;
        a_pc = p; a_alu = alu; a_wd = wdat;
    endtask

    // Holds one request on the wait-state unit until it completes; reports stall cycles.
    task automatic b_access(input logic iord_i, irw_i, mw_i, input logic [31:0] p, alu, wdat,
                            output int stalls, output logic mis_o);
        b_iord = iord_i; b_irw = irw_i; b_mw = mw_i;
        b_pc = p; b_alu = alu; b_wd = wdat;
        stalls = 0;
        mis_o = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (c == 0) mis_o = b_mis;
            if (b_ready) break;
            stalls++;
            @(posedge clock);
        end
        @(posedge clock);
        #1;
        b_iord = 0; b_irw = 0; b_mw = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 32'h0,   32'h0,   32'h8C0A0004, 1'b0, 32'h00000000, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h0,   32'h0,        1'b0, 32'h8C0A0004, 1'b1, 32'h8C0A0004};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h0,   32'h10,  32'hDEADBEEF, 1'b0, 32'h8C0A0004, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h10,  32'h0,        1'b0, 32'h8C0A0004, 1'b1, 32'hDEADBEEF};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h0,   32'h12,  32'h12345678, 1'b1, 32'h8C0A0004, 1'b1, 32'hDEADBEEF};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h10,  32'h0,        1'b0, 32'h8C0A0004, 1'b1, 32'hDEADBEEF};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h400, 32'h0,        1'b0, 32'h8C0A0004, 1'b1, 32'h8C0A0004};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 32'h0,   32'h404, 32'hCAFEF00D, 1'b0, 32'h8C0A0004, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h4,   32'h0,   32'h0,        1'b0, 32'h8C0A0004, 1'b1, 32'hCAFEF00D};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 32'h0,   32'h4,   32'h20080005, 1'b0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 32'h0,   32'h4,   32'h0,        1'b0, 32'hCAFEF00D, 1'b1, 32'h20080005};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 32'h404, 32'h0,   32'h0,        1'b0, 32'h20080005, 1'b1, 32'h20080005};

        a_drive(0, 0, 0, 0, 0, 0);
        b_iord = 0; b_irw = 0; b_mw = 0; b_pc = 0; b_alu = 0; b_wd = 0;

        #1 reset = 1'b0;
        #11 reset = 1'b1;
        #1;
        check("reset_a_instr", a_instr, 32'h0);
        check("reset_a_mdr", a_mem_data, 32'h0);
        check("reset_a_ready", a_ready, 1'b1);
        check("reset_a_opcode", a_opcode, OP_RTYPE);
        check("reset_b_instr", b_instr, 32'h0);
        check("reset_b_mdr", b_mem_data, 32'h0);
        check("reset_b_ready", b_ready, 1'b1);

        // preload every word of the single-cycle memory with known data
        for (int i = 0; i < 256; i++) begin
            @(posedge clock); #1;
            wd = $urandom;
            a_drive(1, 0, 1, 0, 32'(i * 4), wd);
            a_model[i] = wd;
        end
        @(posedge clock); #1;
        a_drive(0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 12; k++) begin
            a_drive(tbl[k].iord, tbl[k].irw, tbl[k].mw, tbl[k].pc, tbl[k].alu, tbl[k].wd);
            #1;
            check($sformatf("tbl%0d_mis", k), a_mis, tbl[k].exp_mis);
            @(posedge clock); #1;
            check($sformatf("tbl%0d_instr", k), a_instr, tbl[k].exp_instr);
            if (tbl[k].chk_mdr) check($sformatf("tbl%0d_mdr", k), a_mem_data, tbl[k].exp_mdr);
            check($sformatf("tbl%0d_ready", k), a_ready, 1'b1);
            if (k == 1) begin
                check("fetch_opcode", a_opcode, OP_LW);
                check("fetch_rs", a_rs, 5'd0);
                check("fetch_rt", a_rt, 5'd10);
                check("fetch_rd", a_rd, 5'd0);
                check("fetch_imm", a_imm, 16'h0004);
                check("fetch_funct", a_funct, 6'b000100);
            end
        end
        a_model[0] = 32'h8C0A0004;
        a_model[4] = 32'hDEADBEEF;
        a_model[1] = 32'h20080005;
        a_ir = 32'h20080005;

        for (int n = 0; n < 300; n++) begin
            iord = 1'($urandom_range(0, 1));
            irw = ($urandom_range(0, 3) == 0);
            mw = ($urandom_range(0, 2) == 0);
            sel = $urandom;
            if ($urandom_range(0, 3) != 0) sel[1:0] = 2'b00;
            other = $urandom;
            wd = $urandom;
            if (iord) a_drive(iord, irw, mw, other, sel, wd);
            else      a_drive(iord, irw, mw, sel, other, wd);
            idx = int'((sel / 4) % 256);
            mis = (sel % 4) != 0;
            #1;
            check("rand_a_mis", a_mis, mis);
            @(posedge clock); #1;
            old = a_model[idx];
            if (irw) a_ir = old;
            if (mw && !mis) a_model[idx] = wd;
            check("rand_a_mdr", a_mem_data, old);
            check("rand_a_instr", a_instr, a_ir);
            check("rand_a_rt", a_rt, a_ir[20:16]);
            check("rand_a_imm", a_imm, a_ir[15:0]);
        end
        a_drive(0, 0, 0, 0, 0, 0);

        // wait-state unit: preload 16 words, each access stalls exactly 3 cycles
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            b_access(1, 0, 1, 0, 32'(i * 4), wd, low, mis_seen);
            check("b_fill_stalls", low, 3);
            b_model[i] = wd;
        end
        b_access(1, 0, 1, 0, 32'h0, 32'h8C0A0004, low, mis_seen);
        b_model[0] = 32'h8C0A0004;

        // IR must only change at the edge that ends the DONE cycle
        b_iord = 0; b_pc = 0; b_irw = 1;
        #1;
        check("ws_c1_ready", b_ready, 1'b0);
        @(posedge clock); #1;
        check("ws_c2_ready", b_ready, 1'b0);
        check("ws_e1_instr", b_instr, 32'h0);
        @(posedge clock); #1;
        check("ws_c3_ready", b_ready, 1'b0);
        check("ws_e2_instr", b_instr, 32'h0);
        @(posedge clock); #1;
        check("ws_c4_ready", b_ready, 1'b1);
        check("ws_e3_instr", b_instr, 32'h0);
        @(posedge clock); #1;
        check("ws_e4_instr", b_instr, 32'h8C0A0004);
        check("ws_e4_mdr", b_mem_data, 32'h8C0A0004);
        check("ws_e4_opcode", b_opcode, OP_LW);
        check("ws_e4_rs", b_rs, 5'd0);
        check("ws_e4_rt", b_rt, 5'd10);
        check("ws_e4_rd", b_rd, 5'd0);
        check("ws_e4_imm", b_imm, 16'h0004);
        check("ws_e4_funct", b_funct, 6'b000100);
        b_irw = 0;
        #1;
        check("ws_idle_ready", b_ready, 1'b1);
        b_ir = 32'h8C0A0004;
        @(posedge clock); #1;

        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 15);
            mis = ($urandom_range(0, 3) == 0);
            sel = 32'(idx * 4) + (32'($urandom_range(0, 7)) << 10) + (mis ? 32'($urandom_range(1, 3)) : 32'h0);
            iord = 1'($urandom_range(0, 1));
            irw = ($urandom_range(0, 2) == 0);
            mw = ($urandom_range(0, 2) == 0);
            if (!iord && !irw && !mw) irw = 1'b1;
            other = $urandom;
            wd = $urandom;
            if (iord) b_access(iord, irw, mw, other, sel, wd, low, mis_seen);
            else      b_access(iord, irw, mw, sel, other, wd, low, mis_seen);
            old = b_model[idx];
            if (irw) b_ir = old;
            if (mw && !mis) b_model[idx] = wd;
            check("rand_b_stalls", low, 3);
            check("rand_b_mis", mis_seen, mis);
            check("rand_b_mdr", b_mem_data, old);
            check("rand_b_instr", b_instr, b_ir);
        end

        // reset pulse while a store to 0x20 is stalled must discard the store
        @(posedge clock); #1;
        b_iord = 1; b_alu = 32'h20; b_wd = 32'hBAD0BAD0; b_mw = 1;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("rst_mid_ready_low", b_ready, 1'b0);
        b_iord = 0; b_mw = 0; b_alu = 0;
        #1 reset = 1'b1;
        #1;
        check("rst_mid_ready", b_ready, 1'b1);
        check("rst_mid_b_instr", b_instr, 32'h0);
        check("rst_mid_b_mdr", b_mem_data, 32'h0);
        check("rst_mid_a_instr", a_instr, 32'h0);
        check("rst_mid_a_mdr", a_mem_data, 32'h0);
        @(posedge clock); #1;
        b_access(1, 0, 0, 0, 32'h20, 32'h0, low, mis_seen);
        check("rst_mid_word8", b_mem_data, b_model[8]);
        check("rst_mid_stalls", low, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
